// File: rtl/ground_scheduler.sv
// Platform table scheduler: once per frame it scrolls the 16 platforms up,
// retires the ones that leave the top and spawns new ones from an LFSR.
module ground_scheduler #(
    parameter int unsigned SPAWN_INTERVAL = 32,
    parameter int unsigned Y_TOP          = 8,
    parameter int unsigned Y_SPAWN        = 479,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              vsync,
    input  logic              enable,
    input  logic [2:0]        scroll_speed,
    output logic [15:0][28:0] info_ground,
    output logic              busy,
    output logic              frame_overrun
);

    typedef enum logic [1:0] {IDLE, SCROLL, SPAWN, DONE} state_t;

    localparam logic [7:0]  TMAX  = 8'(SPAWN_INTERVAL - 1);
    localparam logic [9:0]  YTOP  = 10'(Y_TOP);
    localparam logic [8:0]  YSPN  = 9'(Y_SPAWN);
    localparam logic [28:0] START = {10'd200, 9'd400, 10'd220};
    localparam logic [15:0][28:0] TABLE_RST = {{15{29'h0}}, START};

    state_t      state;
    state_t      state_nx;
    logic        vsync_q;
    logic        tick;
    logic [3:0]  idx;
    logic [2:0]  speed;
    logic [7:0]  timer;
    logic [15:0] lfsr;
    logic [28:0] cur;
    logic [28:0] scrolled;
    logic [28:0] spawned;
    logic        free_any;
    logic [3:0]  free_idx;

    assign tick = vsync & ~vsync_q;
    assign busy = (state != IDLE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (tick && enable) state_nx = SCROLL;
            SCROLL:  if (idx == 4'd15) state_nx = SPAWN;
            SPAWN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Retire when the row would cross the top threshold this frame.
    always_comb begin
        cur      = info_ground[idx];
        scrolled = cur;
        if (cur[28:19] != 10'd0) begin
            if ({1'b0, cur[18:10]} < YTOP + {7'd0, speed})
                scrolled = 29'h0;
            else
                scrolled[18:10] = cur[18:10] - {6'd0, speed};
        end
    end

    // Lowest free slot wins: scanning downward leaves the lowest hit last.
    always_comb begin
        free_any = 1'b0;
        free_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (info_ground[i][28:19] == 10'd0) begin
                free_any = 1'b1;
                free_idx = 4'(i);
            end
        end
    end

    assign spawned = {10'd32 + {4'd0, lfsr[14:10], 1'b0},
                      YSPN, {1'b0, lfsr[8:0]}};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vsync_q       <= 1'b0;
            idx           <= 4'd0;
            speed         <= 3'd0;
            timer         <= 8'd0;
            lfsr          <= LFSR_SEED;
            frame_overrun <= 1'b0;
            info_ground   <= TABLE_RST;
        end else begin
            vsync_q <= vsync;
            if (tick && busy) frame_overrun <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (tick && enable) begin
                        idx   <= 4'd0;
                        speed <= scroll_speed;
                    end
                end
                SCROLL: begin
                    info_ground[idx] <= scrolled;
                    idx              <= idx + 4'd1;
                end
                SPAWN: begin
                    if (timer == TMAX) begin
                        if (free_any) begin
                            info_ground[free_idx] <= spawned;
                            timer                 <= 8'd0;
                        end
                    end else if (timer < TMAX) begin
                        timer <= timer + 8'd1;
                    end
                end
                DONE: begin
                    lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5],
                             lfsr[15:1]};
                end
                default: ;
            endcase
        end
    end

endmodule
